// File: rtl/tl_phase_seq.sv
// -----------------------------------------------------------------------------
// tl_phase_seq -- N-phase traffic-light sequencer.
//
// Cycles the enabled green phases through GREEN -> YELLOW -> ALL_RED. Each
// state runs for a duration counted in ticks of an internal prescaler. At
// every ALL_RED expiry the sequencer may instead enter flashing-yellow mode or
// take a validated manual jump through an OVERRIDE hold.
//
// Parameters:
//   N_PHASES      number of green phases (2..16)
//   TW            width of every duration input, in ticks
//   CLK_PER_TICK  clk cycles per tick (>=1)
//   PW            phase index width (derived)
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   green_ticks   per-phase green duration, phase i at [i*TW +: TW]
//   yellow_ticks  yellow duration (all phases)
//   allred_ticks  all-red duration
//   ovr_ticks     override-hold duration
//   phase_en      phase participates in the normal cycle
//   jump_req      latched manual jump request (level)
//   jump_phase    requested jump target
//   flash_req     request flashing-yellow mode (level)
//   accept_jump   1-cycle pulse, clears the request upstream
//   jump_err      1-cycle pulse, request was invalid and dropped
//   st            0 ALL_RED, 1 GREEN, 2 YELLOW, 3 OVERRIDE, 4 FLASH
//   cur_phase     phase owning GREEN/YELLOW/OVERRIDE, last served otherwise
//   green_oh      one-hot green lamp (GREEN only)
//   yellow_oh     one-hot yellow lamp in YELLOW, all bits = blink in FLASH
//   phase_start   1-cycle pulse on every GREEN entry
// All outputs are registered.
// -----------------------------------------------------------------------------
module tl_phase_seq #(
   parameter int N_PHASES     = 4,
   parameter int TW           = 16,
   parameter int CLK_PER_TICK = 50_000_000,
   localparam int PW          = $clog2(N_PHASES)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_PHASES*TW-1:0] green_ticks,
   input  logic [TW-1:0]          yellow_ticks,
   input  logic [TW-1:0]          allred_ticks,
   input  logic [TW-1:0]          ovr_ticks,
   input  logic [N_PHASES-1:0]    phase_en,
   input  logic                   jump_req,
   input  logic [PW-1:0]          jump_phase,
   input  logic                   flash_req,
   output logic                   accept_jump,
   output logic                   jump_err,
   output logic [2:0]             st,
   output logic [PW-1:0]          cur_phase,
   output logic [N_PHASES-1:0]    green_oh,
   output logic [N_PHASES-1:0]    yellow_oh,
   output logic                   phase_start
);

   localparam int CW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
   localparam logic [CW-1:0] PRESC_MAX = CW'(CLK_PER_TICK - 1);
   localparam logic [PW-1:0] LAST_PHASE = PW'(N_PHASES - 1);

   typedef enum logic [2:0] {
      S_ALL_RED  = 3'd0,
      S_GREEN    = 3'd1,
      S_YELLOW   = 3'd2,
      S_OVERRIDE = 3'd3,
      S_FLASH    = 3'd4
   } state_t;

   // A zero duration behaves as a single tick.
   function automatic logic [TW-1:0] dur_fix(input logic [TW-1:0] d);
      return (d == {TW{1'b0}}) ? {{(TW-1){1'b0}}, 1'b1} : d;
   endfunction

   function automatic logic [N_PHASES-1:0] onehot(input logic [PW-1:0] p);
      return {{(N_PHASES-1){1'b0}}, 1'b1} << p;
   endfunction

   state_t                state_r, state_nx_s;
   logic [PW-1:0]         cur_phase_r, cur_nx_s;
   logic                  blink_r, blink_nx_s;
   logic [N_PHASES-1:0]   green_r, green_nx_s;
   logic [N_PHASES-1:0]   yellow_r, yellow_nx_s;
   logic                  accept_r, acc_nx_s;
   logic                  err_r, err_nx_s;
   logic                  start_r, start_nx_s;

   logic [CW-1:0]         presc_r;
   logic [TW-1:0]         rem_r;
   logic                  init_r;
   logic [TW-1:0]         rem_eff_s;
   logic                  tick_s;
   logic                  expire_s;
   logic                  load_s;
   logic [TW-1:0]         dur_s;

   logic [PW-1:0]         nxt_phase_s;
   logic                  nxt_found_s;
   logic [PW:0]           sum_s;
   logic                  jump_ok_s;

   // Right after reset the remaining count comes straight from allred_ticks,
   // so the first ALL_RED behaves as if loaded at reset.
   assign rem_eff_s = init_r ? dur_fix(allred_ticks) : rem_r;
   assign tick_s    = (presc_r == PRESC_MAX);
   assign expire_s  = tick_s && (rem_eff_s == {{(TW-1){1'b0}}, 1'b1});
   assign jump_ok_s = ({1'b0, jump_phase} < (PW+1)'(N_PHASES)) && phase_en[jump_phase];

   // Next enabled phase after cur_phase, wrapping; may return cur_phase itself.
   always_comb begin
      nxt_found_s = 1'b0;
      nxt_phase_s = cur_phase_r;
      sum_s       = {(PW+1){1'b0}};
      for (int k = 1; k <= N_PHASES; k++) begin
         sum_s = {1'b0, cur_phase_r} + (PW+1)'(k);
         if (sum_s >= (PW+1)'(N_PHASES)) begin
            sum_s = sum_s - (PW+1)'(N_PHASES);
         end else begin
            sum_s = sum_s;
         end
         if (!nxt_found_s && phase_en[sum_s[PW-1:0]]) begin
            nxt_found_s = 1'b1;
            nxt_phase_s = sum_s[PW-1:0];
         end else begin
            nxt_found_s = nxt_found_s;
         end
      end
   end

   // Next-state, next-phase, entry duration and pulse decode.
   always_comb begin
      state_nx_s = state_r;
      cur_nx_s   = cur_phase_r;
      blink_nx_s = blink_r;
      load_s     = 1'b0;
      dur_s      = allred_ticks;
      acc_nx_s   = 1'b0;
      err_nx_s   = 1'b0;
      start_nx_s = 1'b0;
      case (state_r)
         S_GREEN: begin
            if (expire_s) begin
               state_nx_s = S_YELLOW;
               load_s     = 1'b1;
               dur_s      = yellow_ticks;
            end else begin
               state_nx_s = S_GREEN;
            end
         end
         S_YELLOW: begin
            if (expire_s) begin
               state_nx_s = S_ALL_RED;
               load_s     = 1'b1;
               dur_s      = allred_ticks;
            end else begin
               state_nx_s = S_YELLOW;
            end
         end
         S_ALL_RED: begin
            if (!expire_s) begin
               state_nx_s = S_ALL_RED;
            end else if (flash_req) begin
               // Pending jump stays pending while flashing.
               state_nx_s = S_FLASH;
               load_s     = 1'b1;
               dur_s      = {{(TW-1){1'b0}}, 1'b1};
               blink_nx_s = 1'b1;
            end else if (jump_req && jump_ok_s) begin
               state_nx_s = S_OVERRIDE;
               cur_nx_s   = jump_phase;
               load_s     = 1'b1;
               dur_s      = ovr_ticks;
               acc_nx_s   = 1'b1;
            end else begin
               // Invalid request is consumed and flagged, then normal rotation.
               acc_nx_s = jump_req;
               err_nx_s = jump_req;
               load_s   = 1'b1;
               if (nxt_found_s) begin
                  state_nx_s = S_GREEN;
                  cur_nx_s   = nxt_phase_s;
                  dur_s      = green_ticks[nxt_phase_s*TW +: TW];
                  start_nx_s = 1'b1;
               end else begin
                  state_nx_s = S_ALL_RED;
                  dur_s      = allred_ticks;
               end
            end
         end
         S_OVERRIDE: begin
            if (expire_s) begin
               state_nx_s = S_GREEN;
               load_s     = 1'b1;
               dur_s      = green_ticks[cur_phase_r*TW +: TW];
               start_nx_s = 1'b1;
            end else begin
               state_nx_s = S_OVERRIDE;
            end
         end
         S_FLASH: begin
            if (tick_s && !flash_req) begin
               // Restart the rotation at phase 0 after the all-red.
               state_nx_s = S_ALL_RED;
               cur_nx_s   = LAST_PHASE;
               load_s     = 1'b1;
               dur_s      = allred_ticks;
               blink_nx_s = 1'b0;
            end else if (tick_s) begin
               blink_nx_s = ~blink_r;
            end else begin
               blink_nx_s = blink_r;
            end
         end
         default: begin
            state_nx_s = S_ALL_RED;
            cur_nx_s   = LAST_PHASE;
            load_s     = 1'b1;
            dur_s      = allred_ticks;
            blink_nx_s = 1'b0;
         end
      endcase
   end

   // Lamp decode from the next state so the lamps register with st.
   always_comb begin
      green_nx_s  = {N_PHASES{1'b0}};
      yellow_nx_s = {N_PHASES{1'b0}};
      case (state_nx_s)
         S_GREEN:  green_nx_s  = onehot(cur_nx_s);
         S_YELLOW: yellow_nx_s = onehot(cur_nx_s);
         S_FLASH:  yellow_nx_s = {N_PHASES{blink_nx_s}};
         default: begin
            green_nx_s  = {N_PHASES{1'b0}};
            yellow_nx_s = {N_PHASES{1'b0}};
         end
      endcase
   end

   // Prescaler and remaining-tick counter; both restart on every state entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_r <= {CW{1'b0}};
         rem_r   <= {TW{1'b0}};
         init_r  <= 1'b1;
      end else if (load_s) begin
         presc_r <= {CW{1'b0}};
         rem_r   <= dur_fix(dur_s);
         init_r  <= 1'b0;
      end else if (tick_s) begin
         presc_r <= {CW{1'b0}};
         rem_r   <= rem_eff_s - {{(TW-1){1'b0}}, 1'b1};
         init_r  <= 1'b0;
      end else begin
         presc_r <= presc_r + {{(CW-1){1'b0}}, 1'b1};
         rem_r   <= rem_eff_s;
         init_r  <= 1'b0;
      end
   end

   // State, phase and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_ALL_RED;
         cur_phase_r <= LAST_PHASE;
         blink_r     <= 1'b0;
         green_r     <= {N_PHASES{1'b0}};
         yellow_r    <= {N_PHASES{1'b0}};
         accept_r    <= 1'b0;
         err_r       <= 1'b0;
         start_r     <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         cur_phase_r <= cur_nx_s;
         blink_r     <= blink_nx_s;
         green_r     <= green_nx_s;
         yellow_r    <= yellow_nx_s;
         accept_r    <= acc_nx_s;
         err_r       <= err_nx_s;
         start_r     <= start_nx_s;
      end
   end

   assign st          = state_r;
   assign cur_phase   = cur_phase_r;
   assign green_oh    = green_r;
   assign yellow_oh   = yellow_r;
   assign accept_jump = accept_r;
   assign jump_err    = err_r;
   assign phase_start = start_r;

endmodule

// File: tb/tb_tl_phase_seq.sv
// -----------------------------------------------------------------------------
// Bench for tl_phase_seq. Each test resets the DUT, pushes the hand-derived
// per-cycle trace into a queue, and a negedge monitor pops and compares one
// entry per cycle. A second instance with CLK_PER_TICK=3 shares the inputs and
// its st is checked during the normal-cycle test.
// -----------------------------------------------------------------------------
module tb_tl_phase_seq;
   localparam int N  = 4;
   localparam int TW = 16;
   localparam int PW = 2;

   localparam logic [2:0] AR = 3'd0, GR = 3'd1, YE = 3'd2, OV = 3'd3, FL = 3'd4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N*TW-1:0] green_ticks;
   logic [TW-1:0]   yellow_ticks, allred_ticks, ovr_ticks;
   logic [N-1:0]    phase_en;
   logic            jump_req;
   logic [PW-1:0]   jump_phase;
   logic            flash_req;

   logic            accept_jump, jump_err, phase_start;
   logic [2:0]      st;
   logic [PW-1:0]   cur_phase;
   logic [N-1:0]    green_oh, yellow_oh;

   logic            s_acc, s_err, s_start;
   logic [2:0]      s_st;
   logic [PW-1:0]   s_cur;
   logic [N-1:0]    s_green, s_yellow;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [2:0]    st;
      logic [PW-1:0] cur;
      logic [N-1:0]  g;
      logic [N-1:0]  y;
      logic          acc;
      logic          err;
      logic          start;
      logic          s_chk;
      logic [2:0]    s_st;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   tl_phase_seq #(.N_PHASES(N), .TW(TW), .CLK_PER_TICK(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .green_ticks(green_ticks),
      .yellow_ticks(yellow_ticks), .allred_ticks(allred_ticks),
      .ovr_ticks(ovr_ticks), .phase_en(phase_en), .jump_req(jump_req),
      .jump_phase(jump_phase), .flash_req(flash_req),
      .accept_jump(accept_jump), .jump_err(jump_err), .st(st),
      .cur_phase(cur_phase), .green_oh(green_oh), .yellow_oh(yellow_oh),
      .phase_start(phase_start)
   );

   tl_phase_seq #(.N_PHASES(N), .TW(TW), .CLK_PER_TICK(3)) u_slow (
      .clk(clk), .rst_n(rst_n), .green_ticks(green_ticks),
      .yellow_ticks(yellow_ticks), .allred_ticks(allred_ticks),
      .ovr_ticks(ovr_ticks), .phase_en(phase_en), .jump_req(jump_req),
      .jump_phase(jump_phase), .flash_req(flash_req),
      .accept_jump(s_acc), .jump_err(s_err), .st(s_st),
      .cur_phase(s_cur), .green_oh(s_green), .yellow_oh(s_yellow),
      .phase_start(s_start)
   );

   // Monitor: one expected entry per cycle, sampled on the falling edge.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         total++;
         if ({st, cur_phase, green_oh, yellow_oh, accept_jump, jump_err, phase_start} !==
             {e.st, e.cur, e.g, e.y, e.acc, e.err, e.start}) begin
            bad++;
            $display("FAIL trace @%0t got st=%0d cur=%0d g=%b y=%b acc=%b err=%b ps=%b want st=%0d cur=%0d g=%b y=%b acc=%b err=%b ps=%b",
                     $time, st, cur_phase, green_oh, yellow_oh, accept_jump, jump_err, phase_start,
                     e.st, e.cur, e.g, e.y, e.acc, e.err, e.start);
         end
         if (e.s_chk) begin
            total++;
            if (s_st !== e.s_st) begin
               bad++;
               $display("FAIL slow_st @%0t got %0d want %0d", $time, s_st, e.s_st);
            end
         end
      end
   end

   // Push n cycles of one state; pulses only on the first cycle.
   task automatic push(input logic [2:0] s, input int cur, input int n,
                       input logic acc, input logic err, input logic start);
      for (int i = 0; i < n; i++) begin
         exp_t e;
         e.st    = s;
         e.cur   = PW'(cur);
         e.g     = (s == GR) ? (N'(1) << cur) : N'(0);
         e.y     = (s == YE) ? (N'(1) << cur) : N'(0);
         e.acc   = (i == 0) ? acc : 1'b0;
         e.err   = (i == 0) ? err : 1'b0;
         e.start = (i == 0) ? start : 1'b0;
         e.s_chk = 1'b0;
         e.s_st  = 3'd0;
         q.push_back(e);
      end
   endtask

   task automatic push_flash(input int cur, input int n);
      for (int i = 0; i < n; i++) begin
         exp_t e;
         e.st    = FL;
         e.cur   = PW'(cur);
         e.g     = N'(0);
         e.y     = (i % 2 == 0) ? 4'b1111 : 4'b0000;
         e.acc   = 1'b0;
         e.err   = 1'b0;
         e.start = 1'b0;
         e.s_chk = 1'b0;
         e.s_st  = 3'd0;
         q.push_back(e);
      end
   endtask

   task automatic set_cfg(input int g0, input int g1, input int g2, input int g3,
                          input int y, input int ar, input int ov, input logic [N-1:0] en);
      green_ticks  = {TW'(g3), TW'(g2), TW'(g1), TW'(g0)};
      yellow_ticks = TW'(y);
      allred_ticks = TW'(ar);
      ovr_ticks    = TW'(ov);
      phase_en     = en;
   endtask

   // Reset, then release 2 time units after a rising edge.
   task automatic begin_test();
      rst_n     = 1'b0;
      jump_req  = 1'b0;
      flash_req = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 400; i++) begin
         if (q.size() == 0) break;
         @(posedge clk);
         #2;
      end
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL %s drain_timeout left=%0d want 0", name, q.size());
         q.delete();
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      rst_n      = 1'b0;
      jump_req   = 1'b0;
      jump_phase = 2'd0;
      flash_req  = 1'b0;
      set_cfg(5, 6, 7, 8, 2, 1, 3, 4'b1111);
      #23;

      // Normal cycle.
      begin_test();
      push(AR, 3, 1, 0, 0, 0);
      push(GR, 0, 5, 0, 0, 1); push(YE, 0, 2, 0, 0, 0); push(AR, 0, 1, 0, 0, 0);
      push(GR, 1, 6, 0, 0, 1); push(YE, 1, 2, 0, 0, 0); push(AR, 1, 1, 0, 0, 0);
      push(GR, 2, 7, 0, 0, 1); push(YE, 2, 2, 0, 0, 0); push(AR, 2, 1, 0, 0, 0);
      push(GR, 3, 8, 0, 0, 1); push(YE, 3, 2, 0, 0, 0); push(AR, 3, 1, 0, 0, 0);
      push(GR, 0, 5, 0, 0, 1); push(YE, 0, 2, 0, 0, 0);
      // Slow instance: 3 clocks per tick.
      for (int i = 0; i < 45; i++) begin
         q[i].s_chk = 1'b1;
         if (i < 3)       q[i].s_st = AR;
         else if (i < 18) q[i].s_st = GR;
         else if (i < 24) q[i].s_st = YE;
         else if (i < 27) q[i].s_st = AR;
         else             q[i].s_st = GR;
      end
      wait_drain("normal");

      // Skip mask.
      set_cfg(5, 6, 7, 8, 2, 1, 3, 4'b0101);
      begin_test();
      push(AR, 3, 1, 0, 0, 0);
      push(GR, 0, 5, 0, 0, 1); push(YE, 0, 2, 0, 0, 0); push(AR, 0, 1, 0, 0, 0);
      push(GR, 2, 7, 0, 0, 1); push(YE, 2, 2, 0, 0, 0); push(AR, 2, 1, 0, 0, 0);
      push(GR, 0, 5, 0, 0, 1);
      wait_drain("skip");

      // Valid jump to phase 3, raised during G0.
      set_cfg(5, 6, 7, 8, 2, 1, 3, 4'b1111);
      begin_test();
      push(AR, 3, 1, 0, 0, 0);
      push(GR, 0, 5, 0, 0, 1); push(YE, 0, 2, 0, 0, 0); push(AR, 0, 1, 0, 0, 0);
      push(OV, 3, 3, 1, 0, 0);
      push(GR, 3, 8, 0, 0, 1); push(YE, 3, 2, 0, 0, 0); push(AR, 3, 1, 0, 0, 0);
      push(GR, 0, 5, 0, 0, 1);
      wait_cyc(2);
      jump_phase = 2'd3;
      jump_req   = 1'b1;
      wait_cyc(8);
      jump_req   = 1'b0;
      wait_drain("jump_ok");

      // Invalid jump to disabled phase 1.
      set_cfg(5, 6, 7, 8, 2, 1, 3, 4'b1101);
      begin_test();
      push(AR, 3, 1, 0, 0, 0);
      push(GR, 0, 5, 0, 0, 1); push(YE, 0, 2, 0, 0, 0); push(AR, 0, 1, 0, 0, 0);
      push(GR, 2, 7, 1, 1, 1); push(YE, 2, 2, 0, 0, 0); push(AR, 2, 1, 0, 0, 0);
      push(GR, 3, 8, 0, 0, 1);
      wait_cyc(2);
      jump_phase = 2'd1;
      jump_req   = 1'b1;
      wait_cyc(8);
      jump_req   = 1'b0;
      wait_drain("jump_bad");

      // Flash raised during G1, dropped after four flash cycles.
      set_cfg(5, 6, 7, 8, 2, 1, 3, 4'b1111);
      begin_test();
      push(AR, 3, 1, 0, 0, 0);
      push(GR, 0, 5, 0, 0, 1); push(YE, 0, 2, 0, 0, 0); push(AR, 0, 1, 0, 0, 0);
      push(GR, 1, 6, 0, 0, 1); push(YE, 1, 2, 0, 0, 0); push(AR, 1, 1, 0, 0, 0);
      push_flash(1, 4);
      push(AR, 3, 1, 0, 0, 0);
      push(GR, 0, 5, 0, 0, 1);
      wait_cyc(10);
      flash_req = 1'b1;
      wait_cyc(11);
      flash_req = 1'b0;
      wait_drain("flash");

      // All durations zero: every state lasts one cycle.
      set_cfg(0, 0, 0, 0, 0, 0, 0, 4'b1111);
      begin_test();
      push(AR, 3, 1, 0, 0, 0);
      for (int p = 0; p < 4; p++) begin
         push(GR, p, 1, 0, 0, 1); push(YE, p, 1, 0, 0, 0); push(AR, p, 1, 0, 0, 0);
      end
      push(GR, 0, 1, 0, 0, 1);
      wait_drain("zero_dur");

      // No phase enabled: ALL_RED re-arms forever.
      set_cfg(5, 6, 7, 8, 2, 1, 3, 4'b0000);
      begin_test();
      push(AR, 3, 8, 0, 0, 0);
      wait_drain("no_phase");

      // Reset asserted in the second cycle of Y2.
      set_cfg(5, 6, 7, 8, 2, 1, 3, 4'b1111);
      begin_test();
      push(AR, 3, 1, 0, 0, 0);
      push(GR, 0, 5, 0, 0, 1); push(YE, 0, 2, 0, 0, 0); push(AR, 0, 1, 0, 0, 0);
      push(GR, 1, 6, 0, 0, 1); push(YE, 1, 2, 0, 0, 0); push(AR, 1, 1, 0, 0, 0);
      push(GR, 2, 7, 0, 0, 1); push(YE, 2, 1, 0, 0, 0);
      wait_drain("pre_reset");
      rst_n = 1'b0;
      push(AR, 3, 2, 0, 0, 0);
      wait_drain("mid_reset");
      rst_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
